// File: rtl/dec_pkg.sv
// Shared decoder constants and the enabled one-hot decode function.
`timescale 1ns/1ps
package dec_pkg;

  localparam int SEL_W = 2;
  localparam int OUT_W = 4;

  // Enable wins over select: a disabled decoder yields all-zero.
  function automatic logic [OUT_W-1:0] onehot_dec(input logic en, input logic [SEL_W-1:0] sel);
    logic [OUT_W-1:0] word;
    word = '0;
    if (en) word[sel] = 1'b1;
    return word;
  endfunction

endpackage

// File: rtl/dec2to4_core.sv
// Purely combinational enabled 2-to-4 decode; d is {Y3,Y2,Y1,Y0}.
`timescale 1ns/1ps
module dec2to4_core
  import dec_pkg::*;
(
  input  logic             EN,
  input  logic             A1,
  input  logic             A0,
  output logic [OUT_W-1:0] d
);

  // One-hot word for the binary select, zero while disabled.
  always_comb begin
    d = onehot_dec(EN, {A1, A0});
  end

endmodule

// File: rtl/priority_decoder_2to4.sv
// Enabled 2-to-4 decoder with an optional registered, async-reset output stage.
`timescale 1ns/1ps
module priority_decoder_2to4
  import dec_pkg::*;
#(
  parameter bit               OUT_REG = 1'b1,
  parameter logic [OUT_W-1:0] RST_VAL = 4'b0000
) (
  input  logic clk,
  input  logic rst,
  input  logic EN,
  input  logic A1,
  input  logic A0,
  output logic Y3,
  output logic Y2,
  output logic Y1,
  output logic Y0
);

  logic [OUT_W-1:0] dec_w;
  logic [OUT_W-1:0] y_w;

  dec2to4_core u_core (
    .EN (EN),
    .A1 (A1),
    .A0 (A0),
    .d  (dec_w)
  );

  generate
    if (OUT_REG) begin : g_reg
      logic [OUT_W-1:0] y_d;
      logic [OUT_W-1:0] y_q;

      // Next output word is simply the current decode; no hold-last-value path.
      always_comb begin
        y_d = dec_w;
      end

      // Output flops; reset forces RST_VAL immediately and overrides any edge.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) y_q <= RST_VAL;
        else     y_q <= y_d;
      end

      assign y_w = y_q;
    end else begin : g_comb
      // clk has no role on the combinational path.
      logic unused_clk;
      assign unused_clk = clk;

      // Zero-latency path; reset still overrides the decode while asserted.
      always_comb begin
        y_w = rst ? RST_VAL : dec_w;
      end
    end
  endgenerate

  assign {Y3, Y2, Y1, Y0} = y_w;

endmodule

// File: tb/tb_priority_decoder_2to4.sv
`timescale 1ns/1ps
module tb_priority_decoder_2to4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  logic a1  = 1'b0;
  logic a0  = 1'b0;

  logic yr3, yr2, yr1, yr0;
  logic yc3, yc2, yc1, yc0;
  logic [3:0] yr, yc;

  int n_total = 0;
  int n_pass  = 0;

  assign yr = {yr3, yr2, yr1, yr0};
  assign yc = {yc3, yc2, yc1, yc0};

  priority_decoder_2to4 #(.OUT_REG(1'b1), .RST_VAL(4'b0000)) dut_reg (
    .clk(clk), .rst(rst), .EN(en), .A1(a1), .A0(a0),
    .Y3(yr3), .Y2(yr2), .Y1(yr1), .Y0(yr0)
  );

  priority_decoder_2to4 #(.OUT_REG(1'b0), .RST_VAL(4'b0000)) dut_comb (
    .clk(clk), .rst(rst), .EN(en), .A1(a1), .A0(a0),
    .Y3(yc3), .Y2(yc2), .Y1(yc1), .Y0(yc0)
  );

  always #5 clk = ~clk;

  // Reference decode from the rule: bit number sel is set when enabled.
  function automatic logic [3:0] ref_dec(input logic e, input int sel);
    if (!e) return 4'b0000;
    return 4'(2 ** sel);
  endfunction

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  task automatic check_onehot(input string name, input logic [3:0] act);
    n_total++;
    if (!$isunknown(act) && $countones(act) <= 1) n_pass++;
    else $display("FAIL %s: got %b expected popcount<=1 at %0t", name, act, $time);
  endtask

  // Model: the registered output shows the decode of the inputs seen at the
  // last clock edge taken outside reset; reset clears it at once.
  logic [3:0] exp_q = 4'b0000;

  always @(posedge rst) exp_q = 4'b0000;

  always @(posedge clk) begin
    if (!rst) exp_q = ref_dec(en, int'({a1, a0}));
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("reg_model", yr, exp_q);
    check("comb_model", yc, rst ? 4'b0000 : ref_dec(en, int'({a1, a0})));
    check_onehot("reg_onehot", yr);
    check_onehot("comb_onehot", yc);
  end

  // Called just after a rising edge: drive inputs, verify the combinational
  // path immediately, then verify the registered path after the next edge.
  task automatic apply(input logic e, input logic [1:0] s, input logic [3:0] lit, input string name);
    en = e;
    {a1, a0} = s;
    #1;
    check({name, "_comb"}, yc, lit);
    @(posedge clk);
    #1;
    check({name, "_reg"}, yr, lit);
  endtask

  initial begin
    logic [3:0] sweep_lit [4];
    sweep_lit[0] = 4'b0001;
    sweep_lit[1] = 4'b0010;
    sweep_lit[2] = 4'b0100;
    sweep_lit[3] = 4'b1000;

    // Reset is honoured without any clock edge, whatever the inputs.
    en = 1'b1; a1 = 1'b1; a0 = 1'b1;
    #1;
    check("rst_immediate_reg", yr, 4'b0000);
    check("rst_immediate_comb", yc, 4'b0000);
    @(posedge clk); #1;
    check("rst_held_over_edge", yr, 4'b0000);
    #1;
    rst = 1'b0;
    en = 1'b0;
    @(posedge clk); #1;
    check("first_edge_en0", yr, 4'b0000);

    // Enabled sweep of every select code.
    for (int i = 0; i < 4; i++) apply(1'b1, 2'(i), sweep_lit[i], "sweep");

    // Disabled: every select code gives zero.
    for (int i = 3; i >= 0; i--) apply(1'b0, 2'(i), 4'b0000, "en_off");

    // Reset mid-operation drops the output before the next edge.
    apply(1'b1, 2'b10, 4'b0100, "pre_rst");
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_reg", yr, 4'b0000);
    check("mid_rst_comb", yc, 4'b0000);
    @(posedge clk); #1;
    check("mid_rst_hold", yr, 4'b0000);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_resume", yr, 4'b0100);

    // EN toggling every cycle alternates without holding the last word.
    for (int i = 0; i < 6; i++)
      apply((i % 2) == 0, 2'b01, ((i % 2) == 0) ? 4'b0010 : 4'b0000, "toggle");

    // Random traffic with occasional mid-cycle reset pulses.
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      #2;
      rst = 1'b0;
      en = 1'($urandom_range(0, 1));
      {a1, a0} = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 49) == 0) begin
        #1;
        rst = 1'b1;
      end
    end
    @(posedge clk);
    #2;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
